video_timing_sink: RTL and testbench

- Receive-side counterpart of the HDMI pattern generator. Consumes the raw video stream (hSync/vSync/DrawArea/RGB) on the pixel clock.
- Recovers pixel coordinates from the stream and measures line and frame timing.
- Locks once timing is stable and flags any later deviation.
- Captures the colour at a programmable probe coordinate, so generator output can be checked without looking inside the generator.

---
 rtl/video_timing_sink.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_video_timing_sink.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_sink.sv
// video_timing_sink
// Receive-side timing monitor for a raw hsync/vsync/DrawArea/RGB stream.
// Recovers the active-pixel coordinate, measures line and frame geometry,
// locks once consecutive frames agree, flags any later deviation and
// captures the colour seen at a programmable probe coordinate.
module video_timing_sink #(
    parameter int CW          = 12,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync_i,
    input  logic          vsync_i,
    input  logic          de_i,
    input  logic [7:0]    red_i,
    input  logic [7:0]    green_i,
    input  logic [7:0]    blue_i,
    input  logic [CW-1:0] probe_x_i,
    input  logic [CW-1:0] probe_y_i,
    output logic [CW-1:0] rx_x_o,
    output logic [CW-1:0] rx_y_o,
    output logic          rx_valid_o,
    output logic [CW-1:0] h_total_o,
    output logic [CW-1:0] h_active_o,
    output logic [CW-1:0] v_total_o,
    output logic [CW-1:0] v_active_o,
    output logic          frame_done_o,
    output logic          locked_o,
    output logic          timing_err_o,
    output logic [23:0]   probe_rgb_o,
    output logic          probe_valid_o
);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [3:0]    MATCH_MAX = 4'd15;
    localparam logic [3:0]    LOCK_TH   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // Normalised syncs and edge detection
    logic          hs_s, vs_s;
    logic          hs_q_r, vs_q_r, de_q_r;
    logic          hs_rise_s, vs_rise_s, de_fall_s;

    // Horizontal / vertical measurement
    logic [CW-1:0] hcnt_r, line_len_r, de_cnt_r, h_act_r;
    logic [CW-1:0] lcnt_r, act_lines_r;
    logic          have_len_r;
    logic [CW-1:0] line_now_s;
    logic          len_err_s, ovf_s;

    // Values that a publish at this cycle would latch
    logic [CW-1:0] pub_htot_s, pub_hact_s, pub_vtot_s, pub_vact_s;
    logic          tuple_eq_s;

    // Lock FSM
    state_t        state_r, state_nxt_s;
    logic [3:0]    match_r, match_nxt_s;
    logic          publish_s, mismatch_s, locked_nxt_s;

    // Probe
    logic [23:0]   rgb_r;
    logic          probe_hit_s;

    // Syncs are folded to active-high so the rest of the block is polarity-agnostic.
    assign hs_s      = hsync_i ~^ HS_POL;
    assign vs_s      = vsync_i ~^ VS_POL;
    assign hs_rise_s = hs_s & ~hs_q_r;
    assign vs_rise_s = vs_s & ~vs_q_r;
    assign de_fall_s = ~de_i & de_q_r;

    assign line_now_s = sat_inc(hcnt_r);
    assign len_err_s  = hs_rise_s & have_len_r & (line_now_s != line_len_r);
    assign ovf_s      = (hcnt_r == CNT_MAX) | (lcnt_r == CNT_MAX);

    // A line or active run that ends on the vsync edge itself still belongs
    // to the frame being published, so bypass the registered copies then.
    assign pub_htot_s = hs_rise_s ? line_now_s        : line_len_r;
    assign pub_hact_s = de_fall_s ? de_cnt_r          : h_act_r;
    assign pub_vtot_s = hs_rise_s ? sat_inc(lcnt_r)   : lcnt_r;
    assign pub_vact_s = de_fall_s ? sat_inc(act_lines_r) : act_lines_r;

    assign tuple_eq_s = (pub_htot_s == h_total_o) & (pub_hact_s == h_active_o) &
                        (pub_vtot_s == v_total_o) & (pub_vact_s == v_active_o);

    assign probe_hit_s = rx_valid_o & (rx_x_o == probe_x_i) & (rx_y_o == probe_y_i);

    // One-cycle history of normalised syncs and DrawArea for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q_r <= 1'b0;
            vs_q_r <= 1'b0;
            de_q_r <= 1'b0;
        end else begin
            hs_q_r <= hs_s;
            vs_q_r <= vs_s;
            de_q_r <= de_i;
        end
    end

    // Horizontal counters: line period, active run per line, last active width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_r     <= CNT_ZERO;
            line_len_r <= CNT_ZERO;
            de_cnt_r   <= CNT_ZERO;
            h_act_r    <= CNT_ZERO;
            have_len_r <= 1'b0;
        end else begin
            if (hs_rise_s) begin
                line_len_r <= line_now_s;
                hcnt_r     <= CNT_ZERO;
                de_cnt_r   <= de_i ? CNT_ONE : CNT_ZERO;
                have_len_r <= 1'b1;
            end else begin
                hcnt_r   <= sat_inc(hcnt_r);
                de_cnt_r <= de_i ? sat_inc(de_cnt_r) : de_cnt_r;
            end
            if (de_fall_s) begin
                h_act_r <= de_cnt_r;
            end
        end
    end

    // Vertical counters: lines and active lines since the last vsync edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt_r      <= CNT_ZERO;
            act_lines_r <= CNT_ZERO;
        end else begin
            if (vs_rise_s) begin
                lcnt_r      <= CNT_ZERO;
                act_lines_r <= CNT_ZERO;
            end else begin
                lcnt_r      <= hs_rise_s ? sat_inc(lcnt_r) : lcnt_r;
                act_lines_r <= de_fall_s ? sat_inc(act_lines_r) : act_lines_r;
            end
        end
    end

    // Recovered coordinate of the pixel presented one cycle earlier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_o <= 1'b0;
            rx_x_o     <= CNT_ZERO;
            rx_y_o     <= CNT_ZERO;
            rgb_r      <= 24'h00_0000;
        end else begin
            rx_valid_o <= de_i;
            rgb_r      <= {red_i, green_i, blue_i};
            if (de_i && de_q_r) begin
                rx_x_o <= sat_inc(rx_x_o);
            end else begin
                rx_x_o <= CNT_ZERO;
            end
            if (vs_rise_s) begin
                rx_y_o <= CNT_ZERO;
            end else if (de_fall_s) begin
                rx_y_o <= sat_inc(rx_y_o);
            end
        end
    end

    // Probe capture; validity lasts until the next frame begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            probe_rgb_o   <= 24'h00_0000;
            probe_valid_o <= 1'b0;
        end else if (probe_hit_s) begin
            probe_rgb_o   <= rgb_r;
            probe_valid_o <= 1'b1;
        end else if (vs_rise_s) begin
            probe_valid_o <= 1'b0;
        end
    end

    // Lock FSM state and frame-match counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_SEARCH;
            match_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            match_r <= match_nxt_s;
        end
    end

    // Lock FSM next state: overflow always wins, otherwise act on vsync edges.
    always_comb begin
        state_nxt_s = state_r;
        match_nxt_s = match_r;
        publish_s   = 1'b0;
        mismatch_s  = 1'b0;
        if (ovf_s) begin
            state_nxt_s = ST_SEARCH;
            match_nxt_s = 4'd0;
        end else if (vs_rise_s) begin
            case (state_r)
                ST_SEARCH: begin
                    state_nxt_s = ST_MEASURE;
                    match_nxt_s = 4'd0;
                end
                ST_MEASURE: begin
                    state_nxt_s = ST_CHECK;
                    match_nxt_s = 4'd1;
                    publish_s   = 1'b1;
                end
                ST_CHECK: begin
                    publish_s = 1'b1;
                    if (tuple_eq_s) begin
                        if (match_r == MATCH_MAX) begin
                            match_nxt_s = MATCH_MAX;
                        end else begin
                            match_nxt_s = match_r + 4'd1;
                        end
                    end else begin
                        match_nxt_s = 4'd1;
                        mismatch_s  = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_SEARCH;
                    match_nxt_s = 4'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            match_nxt_s = match_r;
        end
    end

    assign locked_nxt_s = (state_nxt_s == ST_CHECK) && (match_nxt_s >= LOCK_TH);

    // Published measurements, publish strobe and lock indication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_total_o    <= CNT_ZERO;
            h_active_o   <= CNT_ZERO;
            v_total_o    <= CNT_ZERO;
            v_active_o   <= CNT_ZERO;
            frame_done_o <= 1'b0;
            locked_o     <= 1'b0;
        end else begin
            if (publish_s) begin
                h_total_o  <= pub_htot_s;
                h_active_o <= pub_hact_s;
                v_total_o  <= pub_vtot_s;
                v_active_o <= pub_vact_s;
            end
            frame_done_o <= publish_s;
            locked_o     <= locked_nxt_s;
        end
    end

    // Sticky error: overflow, or a frame/line deviation seen while locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timing_err_o <= 1'b0;
        end else begin
            timing_err_o <= timing_err_o | ovf_s | (locked_o & (mismatch_s | len_err_s));
        end
    end

endmodule

// File: tb/tb_video_timing_sink.sv
// tb_video_timing_sink
// Directed stream of small frames (20x12 total, 16x8 active) driven into an
// active-high-sync instance and an inverted-sync instance in parallel.
// Expected frame measurements are queued when a publishing vsync edge is
// driven and popped when frame_done_o pulses.
module tb_video_timing_sink;

    localparam int          CW      = 12;
    localparam logic [23:0] PIX_RGB = 24'h123456;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          hsync   = 1'b0;
    logic          vsync   = 1'b0;
    logic          hsync_n = 1'b1;
    logic          vsync_n = 1'b1;
    logic          de_in   = 1'b0;
    logic [7:0]    red     = 8'h00;
    logic [7:0]    green   = 8'h00;
    logic [7:0]    blue    = 8'h00;
    logic [CW-1:0] probe_x = 12'd5;
    logic [CW-1:0] probe_y = 12'd3;

    logic [CW-1:0] rx_x_a, rx_y_a, h_total_a, h_active_a, v_total_a, v_active_a;
    logic          rx_valid_a, frame_done_a, locked_a, timing_err_a, probe_valid_a;
    logic [23:0]   probe_rgb_a;
    logic [CW-1:0] rx_x_b, rx_y_b, h_total_b, h_active_b, v_total_b, v_active_b;
    logic          rx_valid_b, frame_done_b, locked_b, timing_err_b, probe_valid_b;
    logic [23:0]   probe_rgb_b;

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [47:0] sb_q[$];
    logic [47:0] prev_tuple = 48'h0;
    int          pix_x = 5;
    int          pix_y = 3;
    bit          coord_chk = 1'b0;

    always #5 clk = ~clk;

    video_timing_sink #(.CW(CW), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .hsync_i(hsync), .vsync_i(vsync), .de_i(de_in),
        .red_i(red), .green_i(green), .blue_i(blue),
        .probe_x_i(probe_x), .probe_y_i(probe_y),
        .rx_x_o(rx_x_a), .rx_y_o(rx_y_a), .rx_valid_o(rx_valid_a),
        .h_total_o(h_total_a), .h_active_o(h_active_a),
        .v_total_o(v_total_a), .v_active_o(v_active_a),
        .frame_done_o(frame_done_a), .locked_o(locked_a), .timing_err_o(timing_err_a),
        .probe_rgb_o(probe_rgb_a), .probe_valid_o(probe_valid_a)
    );

    video_timing_sink #(.CW(CW), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .hsync_i(hsync_n), .vsync_i(vsync_n), .de_i(de_in),
        .red_i(red), .green_i(green), .blue_i(blue),
        .probe_x_i(probe_x), .probe_y_i(probe_y),
        .rx_x_o(rx_x_b), .rx_y_o(rx_y_b), .rx_valid_o(rx_valid_b),
        .h_total_o(h_total_b), .h_active_o(h_active_b),
        .v_total_o(v_total_b), .v_active_o(v_active_b),
        .frame_done_o(frame_done_b), .locked_o(locked_b), .timing_err_o(timing_err_b),
        .probe_rgb_o(probe_rgb_b), .probe_valid_o(probe_valid_b)
    );

    function automatic logic [47:0] tup(input int h, input int ha, input int v, input int va);
        return {12'(h), 12'(ha), 12'(v), 12'(va)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock of stream, then score any frame_done pulse.
    task automatic drive(input logic hs, input logic vs, input logic de, input logic [23:0] px);
        logic [47:0] exp_t;
        hsync   = hs;
        vsync   = vs;
        hsync_n = ~hs;
        vsync_n = ~vs;
        de_in   = de;
        {red, green, blue} = px;
        @(posedge clk);
        #1;
        if (frame_done_a) begin
            if (sb_q.size() == 0) begin
                check("unexpected_frame_done", 128'(frame_done_a), 128'(1'b0));
            end else begin
                exp_t = sb_q.pop_front();
                done_cnt++;
                check("h_total",  128'(h_total_a),  128'(exp_t[47:36]));
                check("h_active", 128'(h_active_a), 128'(exp_t[35:24]));
                check("v_total",  128'(v_total_a),  128'(exp_t[23:12]));
                check("v_active", 128'(v_active_a), 128'(exp_t[11:0]));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 24'h0);
        end
    endtask

    // One frame: hs on columns 0-1, vs on lines 0-1 (vs edge coincides with
    // an hs edge), active area starts at line 2 / column 3.
    task automatic send_frame(input int htot, input int hact, input int vtot, input int vact,
                              input bit stretch_last, input bit expect_pub);
        if (expect_pub) begin
            sb_q.push_back(prev_tuple);
        end
        for (int l = 0; l < vtot; l++) begin
            int len;
            len = (stretch_last && (l == vtot - 1)) ? htot + 1 : htot;
            for (int c = 0; c < len; c++) begin
                logic hs, vs, de;
                logic [23:0] px;
                hs = (c < 2);
                vs = (l < 2);
                de = (l >= 2) && (l < 2 + vact) && (c >= 3) && (c < 3 + hact);
                px = (de && (l == 2 + pix_y) && (c == 3 + pix_x)) ? PIX_RGB : 24'h0;
                drive(hs, vs, de, px);
                if (coord_chk && (l == 2) && (c == 3)) begin
                    check("first_px_valid", 128'(rx_valid_a), 128'(1'b1));
                    check("first_px_x",     128'(rx_x_a),     128'(0));
                    check("first_px_y",     128'(rx_y_a),     128'(0));
                end
                if (coord_chk && (l == 2 + pix_y) && (c == 3 + pix_x)) begin
                    check("probe_px_x", 128'(rx_x_a), 128'(pix_x));
                    check("probe_px_y", 128'(rx_y_a), 128'(pix_y));
                end
                if (coord_chk && (l == 2 + pix_y) && (c == 3 + hact)) begin
                    check("after_de_valid", 128'(rx_valid_a), 128'(1'b0));
                    check("after_de_x",     128'(rx_x_a),     128'(0));
                end
            end
        end
        prev_tuple = tup(stretch_last ? htot + 1 : htot, hact, vtot, vact);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_a"}, {rx_x_a, rx_y_a, rx_valid_a, h_total_a, h_active_a, v_total_a,
                            v_active_a, frame_done_a, locked_a, timing_err_a, probe_rgb_a,
                            probe_valid_a}, 128'h0);
        check({tag, "_b"}, {rx_x_b, rx_y_b, rx_valid_b, h_total_b, h_active_b, v_total_b,
                            v_active_b, frame_done_b, locked_b, timing_err_b, probe_rgb_b,
                            probe_valid_b}, 128'h0);
    endtask

    // Asynchronous reset asserted between clock edges, then released.
    task automatic mid_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        idle(2);
        rst_n = 1'b1;
        idle(2);
    endtask

    initial begin
        // Power-on reset
        idle(3);
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Nominal 20x12 timing, probe at (5,3)
        send_frame(20, 16, 12, 8, 1'b0, 1'b0);
        check("f1_locked", 128'(locked_a), 128'(1'b0));
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f2_locked", 128'(locked_a), 128'(1'b0));
        coord_chk = 1'b1;
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        coord_chk = 1'b0;
        check("f3_locked",      128'(locked_a),      128'(1'b1));
        check("f3_err",         128'(timing_err_a),  128'(1'b0));
        check("f3_done_cnt",    128'(done_cnt),      128'(2));
        check("f3_probe_rgb",   128'(probe_rgb_a),   128'(PIX_RGB));
        check("f3_probe_valid", 128'(probe_valid_a), 128'(1'b1));
        check("inv_tuple", {h_total_b, h_active_b, v_total_b, v_active_b}, 128'(tup(20, 16, 12, 8)));
        check("inv_locked",     128'(locked_b),      128'(1'b1));
        check("inv_probe_rgb",  128'(probe_rgb_b),   128'(PIX_RGB));

        // Probe just outside the active width
        probe_x = 12'd16;
        probe_y = 12'd0;
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f4_probe_valid", 128'(probe_valid_a), 128'(1'b0));
        check("f4_locked",      128'(locked_a),      128'(1'b1));

        // Mid-stream reset, then relock from scratch
        mid_reset("midreset");
        send_frame(20, 16, 12, 8, 1'b0, 1'b0);
        check("f5_locked", 128'(locked_a), 128'(1'b0));
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f6_locked", 128'(locked_a), 128'(1'b0));
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f7_locked", 128'(locked_a), 128'(1'b1));

        // Last line of a frame stretched to 21 clocks
        send_frame(20, 16, 12, 8, 1'b1, 1'b1);
        check("f8_locked", 128'(locked_a),     128'(1'b1));
        check("f8_err",    128'(timing_err_a), 128'(1'b0));
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f9_locked", 128'(locked_a),     128'(1'b0));
        check("f9_err",    128'(timing_err_a), 128'(1'b1));
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f10_locked", 128'(locked_a), 128'(1'b0));
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f11_locked", 128'(locked_a),     128'(1'b1));
        check("f11_err",    128'(timing_err_a), 128'(1'b1));
        check("f11_htot",   128'(h_total_a),    128'(20));

        // Counter overflow with syncs stalled
        mid_reset("reset2");
        send_frame(20, 16, 12, 8, 1'b0, 1'b0);
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f14_locked", 128'(locked_a), 128'(1'b1));
        idle(2000);
        check("stall_locked", 128'(locked_a),     128'(1'b1));
        check("stall_err",    128'(timing_err_a), 128'(1'b0));
        idle(2100);
        check("ovf_locked", 128'(locked_a),     128'(1'b0));
        check("ovf_err",    128'(timing_err_a), 128'(1'b1));
        check("ovf_err_b",  128'(timing_err_b), 128'(1'b1));
        for (int c = 0; c < 20; c++) begin
            drive(c < 2, 1'b0, 1'b0, 24'h0);
        end
        send_frame(20, 16, 12, 8, 1'b0, 1'b0);
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f16_locked", 128'(locked_a), 128'(1'b0));
        send_frame(20, 16, 12, 8, 1'b0, 1'b1);
        check("f17_locked", 128'(locked_a),     128'(1'b1));
        check("f17_err",    128'(timing_err_a), 128'(1'b1));

        check("sb_drain", 128'(sb_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
